// File: rtl/opb_register_simulink2ppc_snap_if.sv
// OPB slave bus bundle for the simulink2ppc snapshot register.
// Bus vectors use [0:31] ordering, so bit 0 is the MSB.
interface opb_register_simulink2ppc_snap_if;
    logic [0:31] Sl_DBus;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;
    logic        Sl_xferAck;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;

    modport master (
        input  Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck,
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr
    );

    modport slave (
        output Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck,
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr
    );
endinterface

// File: rtl/opb_register_simulink2ppc_snap.sv
// OPB slave register carrying a fabric word to the PowerPC, with
// freshness, overrun and capture-count tracking.
module opb_register_simulink2ppc_snap #(
    parameter logic [31:0] C_BASEADDR   = 32'h01003600,
    parameter logic [31:0] C_HIGHADDR   = 32'h010036FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5"
) (
    input  logic                                  OPB_Clk,
    input  logic                                  OPB_Rst,
    opb_register_simulink2ppc_snap_if.slave       bus,
    input  logic [31:0]                           user_data_in,
    input  logic                                  user_valid
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACK  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]  state, state_n;
    logic [31:0] abus;
    logic [1:0]  off;
    logic        hit;
    logic        take;
    logic [31:0] rd_mux;

    logic [31:0] addr_q;
    logic        rnw_q;
    logic [1:0]  off_q;
    logic        clr_q;
    logic [31:0] dbus_q;

    logic [31:0] data_reg;
    logic        fresh;
    logic        overrun;
    logic [15:0] count;

    logic        ack;
    logic        read_done;
    logic        ctrl_clr;

    assign abus = bus.OPB_ABus;
    assign off  = bus.OPB_ABus[28:29];
    assign hit  = bus.OPB_select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);

    // WAIT holds off a repeat ack while the master keeps select on the same address.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (hit) state_n = S_ACK;
            S_ACK:  state_n = bus.OPB_select ? S_WAIT : S_IDLE;
            S_WAIT: begin
                if (hit && (abus != addr_q))
                    state_n = S_ACK;
                else if (!bus.OPB_select || (abus != addr_q))
                    state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign take = (state_n == S_ACK);
    assign ack  = (state == S_ACK);

    always_comb begin
        rd_mux = '0;
        case (off)
            2'd0: rd_mux = data_reg;
            2'd1: rd_mux = {fresh, overrun, 14'd0, count};
            default: rd_mux = '0;
        endcase
    end

    assign read_done = ack && rnw_q && (off_q == 2'd0);
    assign ctrl_clr  = ack && !rnw_q && clr_q;

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state  <= S_IDLE;
            addr_q <= '0;
            rnw_q  <= 1'b0;
            off_q  <= '0;
            clr_q  <= 1'b0;
            dbus_q <= '0;
        end else begin
            state  <= state_n;
            dbus_q <= '0;
            if (take) begin
                addr_q <= abus;
                rnw_q  <= bus.OPB_RNW;
                off_q  <= off;
                clr_q  <= !bus.OPB_RNW && (off == 2'd2) && bus.OPB_BE[3] && bus.OPB_DBus[31];
                dbus_q <= bus.OPB_RNW ? rd_mux : '0;
            end
        end
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            data_reg <= '0;
            fresh    <= 1'b0;
            overrun  <= 1'b0;
            count    <= '0;
        end else begin
            if (user_valid) begin
                data_reg <= user_data_in;
                fresh    <= 1'b1;
            end else if (read_done) begin
                fresh <= 1'b0;
            end

            if (ctrl_clr)
                overrun <= 1'b0;
            else if (user_valid && fresh && !read_done)
                overrun <= 1'b1;

            if (ctrl_clr)
                count <= user_valid ? 16'd1 : 16'd0;
            else if (user_valid)
                count <= count + 16'd1;
        end
    end

    assign bus.Sl_DBus    = dbus_q;
    assign bus.Sl_xferAck = ack;
    assign bus.Sl_errAck  = 1'b0;
    assign bus.Sl_retry   = 1'b0;
    assign bus.Sl_toutSup = 1'b0;

    logic unused_ok;
    assign unused_ok = &{1'b0, bus.OPB_seqAddr, bus.OPB_BE[0:2], bus.OPB_DBus[0:30],
                         (C_OPB_AWIDTH == 32), (C_OPB_DWIDTH == 32), |C_FAMILY};

endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
// Directed bench for the simulink2ppc snapshot register: table of bus
// operations plus hand sequences for collisions, wrap and reset.
module tb_opb_register_simulink2ppc_snap;

    localparam logic [31:0] BASE   = 32'h01003600;
    localparam logic [31:0] A_DATA = BASE + 32'h0;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_CTRL = BASE + 32'h8;
    localparam logic [31:0] A_RSV  = BASE + 32'hC;

    localparam int K_PUSH  = 0;
    localparam int K_READ  = 1;
    localparam int K_WRITE = 2;
    localparam int K_NOACK = 3;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] exp;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] user_data_in;
    logic        user_valid;
    int          nchecks = 0;
    int          nerrors = 0;
    vec_t        tbl[$];

    opb_register_simulink2ppc_snap_if bus();

    opb_register_simulink2ppc_snap #(
        .C_BASEADDR(32'h01003600),
        .C_HIGHADDR(32'h010036FF)
    ) dut (
        .OPB_Clk     (clk),
        .OPB_Rst     (rst),
        .bus         (bus),
        .user_data_in(user_data_in),
        .user_valid  (user_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input int kind, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input logic [31:0] exp, input string name);
        vec_t v;
        v.kind = kind; v.addr = addr; v.wd = wd; v.be = be; v.exp = exp; v.name = name;
        tbl.push_back(v);
    endtask

    task automatic push(input logic [31:0] d);
        @(negedge clk);
        user_valid   = 1'b1;
        user_data_in = d;
        @(negedge clk);
        user_valid   = 1'b0;
    endtask

    // One OPB transfer; optionally strobes user_valid in the ack cycle.
    task automatic xfer(input logic [31:0] addr, input logic rnw, input logic [31:0] wd,
                        input logic [3:0] be, input logic uv, input logic [31:0] ud,
                        output logic got, output int lat, output logic [31:0] d,
                        output logic [31:0] post);
        got = 1'b0; lat = 0; d = '0;
        @(negedge clk);
        bus.OPB_ABus   = addr;
        bus.OPB_RNW    = rnw;
        bus.OPB_DBus   = wd;
        bus.OPB_BE     = be;
        bus.OPB_select = 1'b1;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk); #1;
            if (bus.Sl_xferAck) begin
                got = 1'b1; lat = i + 1; d = bus.Sl_DBus;
            end
        end
        @(negedge clk);
        bus.OPB_select = 1'b0;
        bus.OPB_RNW    = 1'b1;
        if (uv) begin
            user_valid   = 1'b1;
            user_data_in = ud;
        end
        @(posedge clk); #1;
        post = {bus.Sl_xferAck, 31'd0} | bus.Sl_DBus;
        @(negedge clk);
        user_valid = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic uv, input logic [31:0] ud,
                           input logic [31:0] exp, input string name);
        logic got; int lat; logic [31:0] d, post;
        xfer(addr, 1'b1, '0, 4'hF, uv, ud, got, lat, d, post);
        chk({name, "_ack_latency"}, lat, 1);
        chk({name, "_data"}, d, exp);
        chk({name, "_idle_after"}, post, 0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be,
                            input logic uv, input logic [31:0] ud, input string name);
        logic got; int lat; logic [31:0] d, post;
        xfer(addr, 1'b0, wd, be, uv, ud, got, lat, d, post);
        chk({name, "_ack_latency"}, lat, 1);
        chk({name, "_dbus_zero"}, d, 0);
        chk({name, "_idle_after"}, post, 0);
    endtask

    initial begin
        logic got; int lat; logic [31:0] d, post;
        int acks;

        rst = 1'b1; user_valid = 1'b0; user_data_in = '0;
        bus.OPB_ABus = '0; bus.OPB_BE = '0; bus.OPB_DBus = '0;
        bus.OPB_RNW = 1'b1; bus.OPB_select = 1'b0; bus.OPB_seqAddr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_ack_low", {31'd0, bus.Sl_xferAck}, 0);
        chk("reset_dbus", bus.Sl_DBus, 0);
        chk("tied_outputs", {29'd0, bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup}, 0);

        add(K_READ,  A_STAT, 0, 4'hF, 32'h00000000, "rst_status");
        add(K_READ,  A_DATA, 0, 4'hF, 32'h00000000, "rst_data");
        add(K_NOACK, 32'h01003700, 0, 4'hF, 0, "above_window");
        add(K_NOACK, 32'h010035FC, 0, 4'hF, 0, "below_window");
        add(K_PUSH,  0, 32'hDEADBEEF, 4'hF, 0, "push_deadbeef");
        add(K_READ,  A_STAT, 0, 4'hF, 32'h80000001, "status_fresh");
        add(K_READ,  A_DATA, 0, 4'hF, 32'hDEADBEEF, "data_deadbeef");
        add(K_READ,  A_STAT, 0, 4'hF, 32'h00000001, "status_after_read");
        add(K_WRITE, A_CTRL, 32'h1, 4'b1111, 0, "clear1");
        add(K_READ,  A_STAT, 0, 4'hF, 32'h00000000, "status_cleared");
        add(K_PUSH,  0, 32'h11, 4'hF, 0, "push_11");
        add(K_PUSH,  0, 32'h22, 4'hF, 0, "push_22");
        add(K_READ,  A_STAT, 0, 4'hF, 32'hC0000002, "status_overrun");
        add(K_WRITE, A_CTRL, 32'h1, 4'b1110, 0, "clear_be_off");
        add(K_READ,  A_STAT, 0, 4'hF, 32'hC0000002, "status_be_off");
        add(K_WRITE, A_CTRL, 32'h0, 4'b1111, 0, "ctrl_bit0_zero");
        add(K_READ,  A_STAT, 0, 4'hF, 32'hC0000002, "status_bit0_zero");
        add(K_WRITE, A_CTRL, 32'h1, 4'b1111, 0, "clear2");
        add(K_READ,  A_STAT, 0, 4'hF, 32'h80000000, "status_clear2");
        add(K_READ,  A_DATA, 0, 4'hF, 32'h00000022, "data_22");
        add(K_READ,  A_STAT, 0, 4'hF, 32'h00000000, "status_idle");
        add(K_READ,  A_CTRL, 0, 4'hF, 32'h00000000, "ctrl_reads0");
        add(K_WRITE, A_RSV,  32'hFFFFFFFF, 4'hF, 0, "rsv_write");
        add(K_READ,  A_RSV,  0, 4'hF, 32'h00000000, "rsv_reads0");
        add(K_READ,  A_STAT, 0, 4'hF, 32'h00000000, "status_after_rsv");

        foreach (tbl[i]) begin
            case (tbl[i].kind)
                K_PUSH:  push(tbl[i].wd);
                K_READ:  do_read(tbl[i].addr, 1'b0, '0, tbl[i].exp, tbl[i].name);
                K_WRITE: do_write(tbl[i].addr, tbl[i].wd, tbl[i].be, 1'b0, '0, tbl[i].name);
                default: begin
                    xfer(tbl[i].addr, 1'b1, '0, 4'hF, 1'b0, '0, got, lat, d, post);
                    chk({tbl[i].name, "_no_ack"}, {31'd0, got}, 0);
                end
            endcase
        end

        // Collision: DATA read ack coincides with a new capture.
        push(32'h44);
        do_read(A_DATA, 1'b1, 32'h55, 32'h00000044, "collide_data");
        do_read(A_STAT, 1'b0, '0, 32'h80000002, "collide_status");
        do_read(A_DATA, 1'b0, '0, 32'h00000055, "collide_newdata");
        do_read(A_STAT, 1'b0, '0, 32'h00000002, "collide_status2");

        // CTRL clear coinciding with a capture.
        push(32'h66);
        push(32'h77);
        do_read(A_STAT, 1'b0, '0, 32'hC0000004, "preclear_status");
        do_write(A_CTRL, 32'h1, 4'hF, 1'b1, 32'h88, "clear_collide");
        do_read(A_STAT, 1'b0, '0, 32'h80000001, "clear_collide_status");
        do_read(A_DATA, 1'b0, '0, 32'h00000088, "clear_collide_data");

        // Count wrap after 65536 captures from a cleared state.
        do_write(A_CTRL, 32'h1, 4'hF, 1'b0, '0, "wrap_clear");
        @(negedge clk);
        user_valid = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            user_data_in = i;
            @(negedge clk);
        end
        user_valid = 1'b0;
        do_read(A_STAT, 1'b0, '0, 32'hC0000000, "wrap_status");
        do_read(A_DATA, 1'b0, '0, 32'h0000FFFF, "wrap_data");

        // Select held for 4 cycles yields exactly one ack.
        acks = 0;
        @(negedge clk);
        bus.OPB_ABus = A_STAT; bus.OPB_RNW = 1'b1; bus.OPB_select = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.Sl_xferAck) acks++;
        end
        @(negedge clk);
        bus.OPB_select = 1'b0;
        chk("held_select_acks", acks, 1);

        // Reset arriving with the select drops the pending ack.
        push(32'hAB);
        acks = 0;
        @(negedge clk);
        bus.OPB_ABus = A_DATA; bus.OPB_RNW = 1'b1; bus.OPB_select = 1'b1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus.Sl_xferAck) acks++;
        end
        @(negedge clk);
        bus.OPB_select = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_read_acks", acks, 0);
        do_read(A_STAT, 1'b0, '0, 32'h00000000, "rst_mid_status");
        do_read(A_DATA, 1'b0, '0, 32'h00000000, "rst_mid_data");

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule

// File: doc/opb_register_simulink2ppc_snap.md
Name: opb_register_simulink2ppc_snap

Overview:
- OPB slave register carrying data from fabric to the PowerPC; the opposite direction to the existing ppc2simulink registers.
- Fabric logic presents a 32-bit word with a one-cycle valid strobe. The block holds the word and tracks freshness and overrun, and software reads it over OPB.
- Sits on the same OPB bus as the ppc2simulink registers, in its own address window.

Parameters:
- C_BASEADDR, 32'h01003600: first byte address of the window.
- C_HIGHADDR, 32'h010036FF: last byte address of the window.
- C_OPB_AWIDTH, 32: OPB address width.
- C_OPB_DWIDTH, 32: OPB data width.
- C_FAMILY, "virtex5": target family; informational only.

Ports:
- OPB_Clk  in  1  single clock for the bus and fabric sides.
- OPB_Rst  in  1  synchronous reset, active-high.
- Sl_DBus  out  [0:31]  read data.
- Sl_errAck  out  1  tied 0.
- Sl_retry  out  1  tied 0.
- Sl_toutSup  out  1  tied 0.
- Sl_xferAck  out  1  transfer acknowledge.
- OPB_ABus  in  [0:31]  address.
- OPB_BE  in  [0:3]  byte enables.
- OPB_DBus  in  [0:31]  write data.
- OPB_RNW  in  1  1 = read, 0 = write.
- OPB_select  in  1  bus transaction active.
- OPB_seqAddr  in  1  ignored.
- user_data_in  in  [31:0]  word from the fabric.
- user_valid  in  1  one-cycle strobe that captures user_data_in.

Behaviour:
- Clock and reset: one clock, OPB_Clk. Reset OPB_Rst is synchronous and active-high.
- Reset values: Sl_xferAck=0, Sl_DBus=0, data_reg=0, fresh=0, overrun=0, count=0.
- Reset mid-transaction: the pending ack is dropped. The master's timeout handles it.
- Bit mapping: Sl_DBus[i] = value[31-i] and OPB_DBus[i] = value[31-i], so bus bit 0 is the MSB.
- Hit: OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR. The word offset is OPB_ABus[28:29].
- Register map, by byte offset:
  - 0x0 DATA (RO): data_reg.
  - 0x4 STATUS (RO): bit31=fresh, bit30=overrun, bits15:0=count, all other bits 0.
  - 0x8 CTRL (WO, reads 0): writing bit0=1 clears overrun and count. The write takes effect only when OPB_BE[3]=1.
  - 0xC: reads 0, writes ignored.
- Handshake:
  - Sl_xferAck is registered and pulses high for exactly one cycle, the cycle after a hit, when ack was low the previous cycle.
  - Latency from select to ack is 1 cycle.
  - While select stays high after the ack, no second ack is issued until select drops for at least one cycle or the address changes.
  - Sl_DBus carries read data only in the ack cycle and is 0 otherwise. Writes drive Sl_DBus=0.
  - A non-hit never acks.
- Capture on user_valid=1:
  - data_reg <= user_data_in, visible on the next cycle.
  - fresh <= 1.
  - count <= count+1, wrapping from 0xFFFF to 0x0000.
  - If fresh was already 1 and no DATA read completes in the same cycle, overrun <= 1. overrun is sticky until CTRL is written.
- DATA read: data is sampled into Sl_DBus on the hit cycle. fresh clears in the ack cycle.
- Simultaneous DATA read (ack cycle) and user_valid:
  - The read returns the old data_reg.
  - The new word is captured.
  - fresh ends at 1.
  - overrun is unchanged.
- Simultaneous CTRL clear and user_valid: the clear wins for overrun. count ends at 1.
- STATUS reads have no side effects.

Test Plan:
- Reset: assert OPB_Rst for 3 cycles, then read STATUS -> ack 1 cycle after select; Sl_DBus=0x00000000; no ack when select is outside the window.
- Capture: user_valid with user_data_in=0xDEADBEEF, then read DATA -> 0xDEADBEEF. STATUS before the read = 0x80000001; STATUS after the read = 0x00000001.
- Overrun: two user_valid pulses (0x11, 0x22) with no read between -> STATUS=0xC0000002 and DATA=0x00000022. Write CTRL=0x00000001 with BE=1111 -> STATUS=0x80000000. The same write with BE=1110 -> no change.
- Collision: DATA read with the ack cycle coinciding with user_valid=0x55 while data_reg=0x44 -> read returns 0x44; STATUS then shows fresh=1 and overrun=0.
- Wrap: 65536 user_valid pulses from cleared state -> count=0x0000 and overrun=1. Select held high for 4 cycles -> exactly one ack.
- Reset mid-read: assert OPB_Rst in the cycle after select -> no ack; all registers 0.
